// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and word-width constants for the fetch arbiter
package fetch_pkg;
    localparam int INSTR_W = 19;
    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        HOSTWR = 3'd1,
        FETCH  = 3'd2,
        EXEC   = 3'd3,
        FAULT  = 3'd4
    } state_t;
endpackage

// File: rtl/ack_timer.sv
// ack_timer: counts memory wait cycles and flags the cycle that reaches TIMEOUT
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (no request outstanding, or acknowledged)
//   enable     : a request is waiting this cycle without an acknowledge
//   timeout    : this waiting cycle is the TIMEOUT-th in a row
module ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    // Flags during the last allowed wait cycle so an ack in that cycle still wins.
    assign timeout = enable && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares one instruction memory between host program load and CPU fetch
//   clk, reset            : clock and synchronous active-high reset
//   pc                    : CPU program counter (word address)
//   host_req/addr/wdata   : host write request; host_gnt pulses when accepted
//   host_done             : program load complete, release the CPU
//   mem_req/we/addr/wdata : memory request; mem_ack/mem_rdata : memory response
//   instruction           : registered instruction word for the CPU
//   cpu_hold, cpu_stall   : CPU reset and commit enable (low stall = commit)
//   err                   : sticky fault flag
module fetch_arbiter
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    input  logic               host_req,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [INSTR_W-1:0] host_wdata,
    input  logic               host_done,
    output logic               host_gnt,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_hold,
    output logic               cpu_stall,
    output logic               err
);
    state_t state, next;
    logic ret_fetch, done_pend, gnt_q, take_host, timed_out, wait_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INSTR_W-1:0] wr_data, instr_q;
    wire pc_ok = pc[31:ADDR_W] == '0;
    wire acked = mem_req && mem_ack;
    wire hold_st = state == LOAD || (state == HOSTWR && !ret_fetch);
    assign wait_en = mem_req && !mem_ack;
    ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(!wait_en),
        .enable(wait_en),
        .timeout(timed_out)
    );
    always_comb begin
        next = state;
        take_host = 1'b0;
        case (state)
            // gnt_q marks the grant cycle; the host may still hold host_req then.
            LOAD: begin
                if (host_req && !gnt_q) begin
                    next = HOSTWR;
                    take_host = 1'b1;
                end else if (host_done || done_pend) next = FETCH;
            end
            HOSTWR: next = acked ? (ret_fetch ? FETCH : LOAD) : (timed_out ? FAULT : HOSTWR);
            FETCH: next = !pc_ok ? FAULT : (acked ? EXEC : (timed_out ? FAULT : FETCH));
            EXEC: begin
                next = host_req ? HOSTWR : FETCH;
                take_host = host_req;
            end
            FAULT: next = FAULT;
            default: next = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            instr_q <= '0;
            done_pend <= 1'b0;
            gnt_q <= 1'b0;
            ret_fetch <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= next;
            gnt_q <= state == HOSTWR && acked;
            // Host fields are captured at acceptance so the request stays stable until ack.
            if (take_host) begin
                ret_fetch <= state == EXEC;
                wr_addr <= host_addr;
                wr_data <= host_wdata;
            end
            if (state == FETCH && acked) instr_q <= mem_rdata;
            done_pend <= (state == LOAD && next == FETCH) ? 1'b0 : (done_pend || (host_done && hold_st));
        end
    end
    assign host_gnt = gnt_q && !reset;
    assign mem_req = !reset && (state == HOSTWR || (state == FETCH && pc_ok));
    assign mem_we = !reset && state == HOSTWR;
    assign mem_addr = state == HOSTWR ? wr_addr : pc[ADDR_W-1:0];
    assign mem_wdata = wr_data;
    assign instruction = instr_q;
    assign cpu_hold = reset || hold_st;
    assign cpu_stall = reset || state != EXEC;
    assign err = state == FAULT;
endmodule

// File: tb/tb_fetch_arbiter.sv
// tb_fetch_arbiter: randomized self-checking bench against a host-view memory model
module tb_fetch_arbiter;
    localparam int ADDR_W = 8;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] pc = '0;
    logic host_req = 1'b0, host_done = 1'b0, mem_ack = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [18:0] host_wdata = '0, mem_rdata = '0;
    logic host_gnt, mem_req, mem_we, cpu_hold, cpu_stall, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [18:0] mem_wdata, instruction;
    logic [18:0] ref_mem [256];
    logic [18:0] emem [256];
    int checks = 0, errors = 0;

    fetch_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_done(host_done), .host_gnt(host_gnt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
        .cpu_hold(cpu_hold), .cpu_stall(cpu_stall), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] rand_word();
        return 19'($urandom) | 19'd1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        host_req = 1'b0;
        host_done = 1'b0;
        mem_ack = 1'b0;
        pc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory responder: waits for a request, holds ack off for lat cycles, then acks once.
    task automatic mem_cycle(input int lat, output logic [7:0] a, output logic we, output logic s, output int w);
        logic [18:0] wd;
        a = '0; we = 1'b0; s = 1'b0; w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_req_wait: mem_req=%b, required 1 within 20 cycles", mem_req);
        end else begin
            a = mem_addr; we = mem_we; s = cpu_stall; wd = mem_wdata;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== a || mem_we !== we || mem_wdata !== wd || (!we && cpu_stall !== 1'b1)) begin
                    errors++;
                    $display("FAIL mem_stable: req=%b addr=%h we=%b wdata=%h stall=%b, required req=1 addr=%h we=%b wdata=%h", mem_req, mem_addr, mem_we, mem_wdata, cpu_stall, a, we, wd);
                end
            end
            mem_ack = 1'b1;
            mem_rdata = we ? 19'($urandom) : emem[a];
            if (we) emem[a] = wd;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 19'($urandom);
        end
    endtask

    task automatic host_write(input logic [7:0] addr, input logic [18:0] data, input int lat);
        logic [7:0] a; logic we, s; int w;
        host_req = 1'b1; host_addr = addr; host_wdata = data;
        ref_mem[addr] = data;
        mem_cycle(lat, a, we, s, w);
        checks++;
        if (a !== addr || we !== 1'b1) begin
            errors++;
            $display("FAIL host_write_req: addr=%h we=%b, required addr=%h we=1", a, we, addr);
        end
        checks++;
        if (host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL host_gnt: got %b, required 1", host_gnt);
        end
        host_req = 1'b0;
    endtask

    task automatic load_words(input int n, input int lat);
        for (int i = 0; i < n; i++) host_write(8'(i), rand_word(), lat < 0 ? int'($urandom_range(0, 4)) : lat);
    endtask

    task automatic fetch_one(input logic [31:0] p, input int lat, input int exp_w);
        logic [7:0] a; logic we, s; int w;
        pc = p;
        mem_cycle(lat, a, we, s, w);
        checks++;
        if (a !== p[7:0] || we !== 1'b0 || s !== 1'b1 || (exp_w >= 0 && w != exp_w)) begin
            errors++;
            $display("FAIL fetch_req: addr=%h we=%b stall=%b gap=%0d, required addr=%h we=0 stall=1 gap=%0d", a, we, s, w, p[7:0], exp_w);
        end
        checks++;
        if (cpu_stall !== 1'b0 || instruction !== ref_mem[p[7:0]]) begin
            errors++;
            $display("FAIL commit: stall=%b instr=%h, required stall=0 instr=%h", cpu_stall, instruction, ref_mem[p[7:0]]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || cpu_stall !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || host_gnt !== 1'b0 || instruction !== 19'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: hold=%b stall=%b req=%b we=%b gnt=%b instr=%h err=%b, required 1 1 0 0 0 0 0", cpu_hold, cpu_stall, mem_req, mem_we, host_gnt, instruction, err);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: hold=%b stall=%b req=%b, required 1 1 0", cpu_hold, cpu_stall, mem_req);
        end
        mem_ack = 1'b1;
        mem_rdata = rand_word();
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (instruction !== 19'd0 || cpu_hold !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: instr=%h hold=%b req=%b, required instr=0 hold=1 req=0", instruction, cpu_hold, mem_req);
        end
    endtask

    task automatic test_load();
        do_reset();
        load_words(3, 2);
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL load_hold: hold=%b, required 1", cpu_hold);
        end
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
        checks++;
        if (host_gnt !== 1'b0 || cpu_hold !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL release: gnt=%b hold=%b req=%b addr=%h we=%b, required 0 0 1 00 0", host_gnt, cpu_hold, mem_req, mem_addr, mem_we);
        end
    endtask

    task automatic test_zero_wait();
        fetch_one(0, 0, 0);
        fetch_one(1, 0, 1);
        fetch_one(2, 0, 1);
    endtask

    task automatic test_random_run();
        do_reset();
        load_words(16, -1);
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
        fetch_one(0, 0, 0);
        for (int i = 0; i < 20; i++) fetch_one(32'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 1);
    endtask

    task automatic test_host_midrun();
        logic [7:0] a, ha; logic we, s; int w;
        logic [18:0] d;
        ha = 8'($urandom_range(16, 255));
        d = rand_word();
        pc = 32'd5;
        @(negedge clk);
        host_req = 1'b1; host_addr = ha; host_wdata = d;
        mem_cycle(2, a, we, s, w);
        checks++;
        if (a !== 8'd5 || cpu_stall !== 1'b0 || instruction !== ref_mem[5]) begin
            errors++;
            $display("FAIL midrun_fetch: addr=%h stall=%b instr=%h, required 05 0 %h", a, cpu_stall, instruction, ref_mem[5]);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ha || mem_wdata !== d || cpu_hold !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL midrun_write: req=%b we=%b addr=%h wdata=%h hold=%b stall=%b, required 1 1 %h %h 0 1", mem_req, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_stall, ha, d);
        end
        ref_mem[ha] = d;
        mem_cycle(int'($urandom_range(0, 3)), a, we, s, w);
        host_req = 1'b0;
        checks++;
        if (host_gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd5) begin
            errors++;
            $display("FAIL midrun_refetch: gnt=%b req=%b we=%b addr=%h, required 1 1 0 05", host_gnt, mem_req, mem_we, mem_addr);
        end
        fetch_one(5, 1, 0);
        fetch_one({24'd0, ha}, 0, 1);
    endtask

    task automatic test_timeout();
        int n;
        fetch_one(3, TIMEOUT - 1, 1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL last_cycle_ack: err=%b, required 0", err);
        end
        pc = 32'd4;
        @(negedge clk);
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TIMEOUT || err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout: wait=%0d err=%b req=%b, required wait=%0d err=1 req=0", n, err, mem_req, TIMEOUT);
        end
        for (int i = 0; i < 6; i++) begin
            mem_ack = 1'($urandom);
            host_req = 1'($urandom);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || mem_req !== 1'b0 || cpu_stall !== 1'b1 || cpu_hold !== 1'b0) begin
                errors++;
                $display("FAIL fault_sticky: err=%b req=%b stall=%b hold=%b, required 1 0 1 0", err, mem_req, cpu_stall, cpu_hold);
            end
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL fault_reset: err=%b hold=%b, required 0 1", err, cpu_hold);
        end
    endtask

    task automatic test_pc_range();
        logic seen;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            load_words(1, 0);
            pc = k == 0 ? 32'h100 : ((32'($urandom_range(1, 32'h00FF_FFFF)) << 8) | 32'($urandom_range(0, 255)));
            host_done = 1'b1;
            @(negedge clk);
            host_done = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                seen = seen | (mem_req === 1'b1);
                @(negedge clk);
            end
            checks++;
            if (seen !== 1'b0 || err !== 1'b1) begin
                errors++;
                $display("FAIL pc_range: pc=%h req_seen=%b err=%b, required req_seen=0 err=1", pc, seen, err);
            end
        end
    endtask

    task automatic test_done_with_req();
        logic [7:0] a; logic we, s; int w, n;
        logic [18:0] d;
        do_reset();
        d = rand_word();
        ref_mem[0] = d;
        host_req = 1'b1; host_done = 1'b1; host_addr = 8'd0; host_wdata = d;
        @(negedge clk);
        host_done = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL done_req_write: req=%b we=%b hold=%b, required 1 1 1", mem_req, mem_we, cpu_hold);
        end
        mem_cycle(1, a, we, s, w);
        host_req = 1'b0;
        n = 0;
        while (cpu_hold !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cpu_hold !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'd0) begin
            errors++;
            $display("FAIL done_remembered: hold=%b req=%b addr=%h, required 0 1 00", cpu_hold, mem_req, mem_addr);
        end
        fetch_one(0, 0, 0);
    endtask

    task automatic test_reset_midfetch();
        pc = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || instruction === 19'd0) begin
            errors++;
            $display("FAIL midfetch_setup: req=%b instr=%h, required req=1 instr nonzero", mem_req, instruction);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || cpu_stall !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midfetch_reset: hold=%b stall=%b req=%b we=%b gnt=%b, required 1 1 0 0 0", cpu_hold, cpu_stall, mem_req, mem_we, host_gnt);
        end
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = rand_word();
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (instruction !== 19'd0 || cpu_hold !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: instr=%h hold=%b err=%b req=%b, required 0 1 0 0", instruction, cpu_hold, err, mem_req);
        end
        host_done = 1'b1;
        @(negedge clk);
        host_done = 1'b0;
        fetch_one(0, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            emem[i] = '0;
        end
        test_reset();
        test_load();
        test_zero_wait();
        test_random_run();
        test_host_midrun();
        test_timeout();
        test_pc_range();
        test_done_with_req();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, the instruction-memory word-address width.
REQ-002 Parameter TIMEOUT, default 15, the maximum cycles to wait for MEM_ACK before faulting.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 PC  input  32  CPU program counter (word address).
REQ-006 HOST_REQ  input  1  host requests one instruction-memory write.
REQ-007 HOST_ADDR  input  ADDR_W  host write address.
REQ-008 HOST_WDATA  input  19  host write data (one instruction word).
REQ-009 HOST_DONE  input  1  one-cycle pulse: program load complete, release CPU.
REQ-010 HOST_GNT  output  1  one-cycle pulse: host write accepted by memory.
REQ-011 MEM_REQ / MEM_WE  output  1 each  memory request strobe and write select.
REQ-012 MEM_ADDR  output  ADDR_W; MEM_WDATA  output  19.
REQ-013 MEM_ACK  input  1; MEM_RDATA  input  19  read data, valid with MEM_ACK.
REQ-014 INSTRUCTION  output  19  registered instruction word presented to the CPU.
REQ-015 CPU_HOLD  output  1  drives CPU RESET; high holds the CPU at PC 0.
REQ-016 CPU_STALL  output  1  low for exactly the one cycle in which the CPU may commit.
REQ-017 ERR  output  1  sticky fault flag.

Function
REQ-018 States: LOAD, HOSTWR, FETCH, EXEC, FAULT; encoded as 3 bits.
REQ-019 LOAD: CPU_HOLD=1, CPU_STALL=1; HOST_REQ -> HOSTWR; HOST_DONE (no HOST_REQ) -> FETCH; both asserted together -> HOSTWR, with HOST_DONE remembered and acted on after the write.
REQ-020 HOSTWR: MEM_REQ=1, MEM_WE=1, MEM_ADDR=HOST_ADDR, MEM_WDATA=HOST_WDATA; on MEM_ACK pulse HOST_GNT next cycle and return to the originating state (LOAD or FETCH).
REQ-021 FETCH: CPU_HOLD=0, MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC[ADDR_W-1:0]; on MEM_ACK, INSTRUCTION<=MEM_RDATA and go to EXEC.
REQ-022 EXEC: CPU_STALL=0 for one cycle, MEM_REQ=0; next state FETCH, or HOSTWR if HOST_REQ is high.
REQ-023 Host writes during run are granted only at the EXEC->FETCH boundary; an in-flight fetch is never aborted; after the write the fetch restarts with the current PC.
REQ-024 MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable from request until MEM_ACK.
REQ-025 Minimum fetch-to-commit latency: 2 cycles (ack in first FETCH cycle -> EXEC next cycle).
REQ-026 A wait counter counts cycles with MEM_REQ=1 and no MEM_ACK; reaching TIMEOUT -> FAULT.
REQ-027 PC[31:ADDR_W] nonzero in FETCH -> FAULT without issuing MEM_REQ.
REQ-028 FAULT: ERR=1, CPU_STALL=1, CPU_HOLD=0 (PC preserved for debug), MEM_REQ=0; exited only by RESET.
REQ-029 MEM_ACK outside a request is ignored.

Reset
REQ-030 RESET high at a CLK edge -> state LOAD, INSTRUCTION=0, ERR=0, wait counter=0, pending HOST_DONE cleared.
REQ-031 Outputs during and after reset: CPU_HOLD=1, CPU_STALL=1, MEM_REQ=0, MEM_WE=0, HOST_GNT=0.
REQ-032 RESET mid-transaction abandons it; a late MEM_ACK is ignored per REQ-029.

Structure
REQ-033 State encoding and the opcode-independent constants (instruction width 19) live in a shared package fetch_pkg.
REQ-034 One sub-module, ack_timer, implements the wait counter with clear/enable and a timeout flag.

Verification
REQ-035 Load 3 words (addr 0..2, MEM_ACK after 2 cycles each), HOST_DONE -> three HOST_GNT pulses, CPU_HOLD falls, first fetch MEM_ADDR=0.
REQ-036 Zero-wait memory, PC stepping 0,1,2 -> CPU_STALL low every 2nd cycle, INSTRUCTION matches stored words.
REQ-037 HOST_REQ asserted mid-fetch at PC=5 -> fetch completes, EXEC, then MEM_WE=1 write, then refetch of PC=5.
REQ-038 MEM_ACK withheld 15 cycles -> ERR=1, MEM_REQ=0, held until RESET.
REQ-039 PC=0x100 with ADDR_W=8 -> ERR=1, no MEM_REQ issued.
REQ-040 RESET pulsed during a read wait, ACK arriving one cycle later -> state LOAD, INSTRUCTION=0, ack ignored.
